// File: rtl/pixel_stream_processor_pkg.sv
// Shared definitions for the pixel stream processor: mode and FSM encodings,
// and the all-ones channel maximum.
`ifndef PIXEL_STREAM_PROCESSOR_PKG_SV
`define PIXEL_STREAM_PROCESSOR_PKG_SV

`define PSP_MAX(w) ({(w){1'b1}})

package pixel_stream_processor_pkg;

   localparam int unsigned ModeW     = 3;
   localparam int unsigned FrameCntW = 16;

   typedef enum logic [ModeW-1:0] {
      MODE_PASS    = 3'd0,
      MODE_INVERT  = 3'd1,
      MODE_ADD     = 3'd2,
      MODE_SUB     = 3'd3,
      MODE_THRESH  = 3'd4,
      MODE_GRAY    = 3'd5,
      MODE_REVERSE = 3'd6,
      MODE_RSVD    = 3'd7
   } mode_e;

   typedef enum logic [0:0] {
      StIdle  = 1'b0,
      StFrame = 1'b1
   } state_e;

endpackage

`endif

// File: rtl/pixel_stream_processor_if.sv
// Valid/ready pixel stream with frame-last flag; master drives the payload.
interface pixel_stream_processor_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_CH   = 3
) ();

   logic                     valid;
   logic                     ready;
   logic [N_CH*DATA_W-1:0]   data;
   logic                     last;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/pixel_channel_alu.sv
// Combinational single-channel operation for the per-channel modes
// (pass/invert/saturating add/saturating sub/threshold).
module pixel_channel_alu
   import pixel_stream_processor_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  mode_e              mode_i,
   input  logic [DATA_W-1:0]  param_i,
   input  logic [DATA_W-1:0]  x_i,
   output logic [DATA_W-1:0]  y_o
);

   localparam logic [DATA_W-1:0] Max = `PSP_MAX(DATA_W);

   logic [DATA_W:0] sum;

   always_comb begin
      sum = {1'b0, x_i} + {1'b0, param_i};
      y_o = x_i;
      case (mode_i)
         MODE_INVERT: y_o = Max - x_i;
         MODE_ADD:    y_o = sum[DATA_W] ? Max : sum[DATA_W-1:0];
         MODE_SUB:    y_o = (x_i >= param_i) ? (x_i - param_i) : '0;
         MODE_THRESH: y_o = (x_i >= param_i) ? Max : '0;
         default:     y_o = x_i;
      endcase
   end

endmodule

// File: rtl/pixel_stream_processor.sv
// Two-stage per-pixel processor with a global stall; mode/param are latched
// on the first beat of each frame and held until its last beat.
module pixel_stream_processor
   import pixel_stream_processor_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned N_CH   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ModeW-1:0]      mode,
   input  logic [DATA_W-1:0]     param,
   pixel_stream_processor_if.slave  in_if,
   pixel_stream_processor_if.master out_if,
   output logic                  busy,
   output logic [FrameCntW-1:0]  frame_cnt
);

   localparam int unsigned PixW = N_CH * DATA_W;
   localparam int unsigned SumW = DATA_W + 2;

   logic en, accept, emit;

   state_e              state_q, state_d;
   mode_e               mode_q, mode_d, eff_mode;
   logic [DATA_W-1:0]   param_q, param_d, eff_param;

   logic                s1_valid_q, s1_last_q;
   logic [PixW-1:0]     s1_data_q;
   mode_e               s1_mode_q;
   logic [DATA_W-1:0]   s1_param_q;

   logic                s2_valid_q, s2_last_q;
   logic [PixW-1:0]     s2_data_q;

   logic [FrameCntW-1:0] frame_cnt_q;

   logic [PixW-1:0]     alu_out, result;
   logic [SumW-1:0]     gray_sum, gray_avg;

   assign en          = !s2_valid_q | out_if.ready;
   assign in_if.ready = en & !reset;
   assign accept      = in_if.valid & in_if.ready;
   assign emit        = s2_valid_q & out_if.ready;

   // The first beat of a frame uses the live mode/param it also latches.
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      param_d   = param_q;
      eff_mode  = mode_q;
      eff_param = param_q;
      case (state_q)
         StIdle: begin
            eff_mode  = mode_e'(mode);
            eff_param = param;
            if (accept) begin
               mode_d  = mode_e'(mode);
               param_d = param;
               if (!in_if.last) state_d = StFrame;
            end
         end
         StFrame: begin
            if (accept && in_if.last) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         mode_q  <= MODE_PASS;
         param_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         param_q <= param_d;
      end
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_alu
      pixel_channel_alu #(
         .DATA_W (DATA_W)
      ) u_alu (
         .mode_i  (s1_mode_q),
         .param_i (s1_param_q),
         .x_i     (s1_data_q[ch*DATA_W +: DATA_W]),
         .y_o     (alu_out[ch*DATA_W +: DATA_W])
      );
   end

   always_comb begin
      gray_sum = '0;
      for (int i = 0; i < N_CH; i++) begin
         gray_sum = gray_sum + SumW'(s1_data_q[i*DATA_W +: DATA_W]);
      end
      gray_avg = gray_sum / SumW'(N_CH);
      result   = alu_out;
      case (s1_mode_q)
         MODE_GRAY: begin
            for (int i = 0; i < N_CH; i++) result[i*DATA_W +: DATA_W] = gray_avg[DATA_W-1:0];
         end
         MODE_REVERSE: begin
            for (int i = 0; i < N_CH; i++) begin
               result[i*DATA_W +: DATA_W] = s1_data_q[(N_CH-1-i)*DATA_W +: DATA_W];
            end
         end
         default: ;
      endcase
   end

   // Payload registers only load with valid data so idle inputs never reach the output.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= MODE_PASS;
         s1_param_q <= '0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s2_data_q  <= '0;
      end else if (en) begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_data_q  <= in_if.data;
            s1_last_q  <= in_if.last;
            s1_mode_q  <= eff_mode;
            s1_param_q <= eff_param;
         end
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_data_q <= result;
            s2_last_q <= s1_last_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
      end else if (emit && s2_last_q) begin
         frame_cnt_q <= frame_cnt_q + FrameCntW'(1);
      end
   end

   assign out_if.valid = s2_valid_q;
   assign out_if.data  = s2_data_q;
   assign out_if.last  = s2_last_q;
   assign frame_cnt    = frame_cnt_q;
   assign busy         = (state_q == StFrame) | s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_pixel_stream_processor.sv
// Directed and randomized checks of pixel_stream_processor against a
// frame-level reference model and an expected-pixel queue.
module tb_pixel_stream_processor;

   localparam int DW = 8;
   localparam int NC = 3;
   localparam int PW = DW * NC;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    mode;
   logic [DW-1:0] param;
   logic          busy;
   logic [15:0]   frame_cnt;

   always #5 clk = ~clk;

   pixel_stream_processor_if #(.DATA_W(DW), .N_CH(NC)) in_if ();
   pixel_stream_processor_if #(.DATA_W(DW), .N_CH(NC)) out_if ();

   pixel_stream_processor #(
      .DATA_W (DW),
      .N_CH   (NC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .param     (param),
      .in_if     (in_if),
      .out_if    (out_if),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   typedef struct {
      logic [PW-1:0] d;
      logic          l;
      int unsigned   cyc;
   } exp_t;

   exp_t          q[$];
   int            checks = 0;
   int            errors = 0;
   int unsigned   cyc_n = 0;
   bit            lat_chk = 0;
   bit            rand_rdy = 0;
   bit            m_open = 0;
   int            m_mode = 0;
   int            m_param = 0;
   logic [15:0]   m_fcnt = '0;
   bit            last_acc = 0;
   bit            use_fixed = 0;
   logic [PW-1:0] fixed_exp;
   bit            stall_v = 0;
   logic [PW:0]   stall_dl;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [PW-1:0] px(input int a, input int b, input int c);
      logic [DW-1:0] a8, b8, c8;
      a8 = DW'(a);
      b8 = DW'(b);
      c8 = DW'(c);
      return {c8, b8, a8};
   endfunction

   function automatic logic [PW-1:0] ref_px(input int md, input int pr, input logic [PW-1:0] p);
      int c[NC];
      int r;
      int s;
      int mx;
      logic [PW-1:0] o;
      mx = (1 << DW) - 1;
      s = 0;
      o = '0;
      for (int i = 0; i < NC; i++) begin
         c[i] = int'(p[i*DW +: DW]);
         s += c[i];
      end
      for (int i = 0; i < NC; i++) begin
         case (md)
            1: r = mx - c[i];
            2: r = (c[i] + pr > mx) ? mx : c[i] + pr;
            3: r = (c[i] - pr < 0) ? 0 : c[i] - pr;
            4: r = (c[i] >= pr) ? mx : 0;
            5: r = s / NC;
            6: r = c[NC-1-i];
            default: r = c[i];
         endcase
         o[i*DW +: DW] = DW'(r);
      end
      return o;
   endfunction

   // One clock: observe and score at the falling edge, then advance past the rising edge.
   task automatic cyc();
      exp_t e;
      bit acc, emt;
      acc = 0;
      emt = 0;
      @(negedge clk);
      if (reset) begin
         chk("rst_in_ready", 32'(in_if.ready), 0);
         stall_v = 0;
      end else begin
         chk("in_ready", 32'(in_if.ready), 32'(!(out_if.valid && !out_if.ready)));
         chk("busy", 32'(busy), 32'(m_open || q.size() != 0));
         chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
         if (stall_v) chk("hold", 32'({out_if.last, out_if.data}), 32'(stall_dl));
         stall_v  = out_if.valid && !out_if.ready;
         stall_dl = {out_if.last, out_if.data};
         acc = in_if.valid && in_if.ready;
         emt = out_if.valid && out_if.ready;
         if (emt) begin
            if (q.size() == 0) begin
               chk("spurious_out", 32'(out_if.valid), 0);
            end else begin
               e = q.pop_front();
               chk("out_data", 32'(out_if.data), 32'(e.d));
               chk("out_last", 32'(out_if.last), 32'(e.l));
               if (lat_chk) chk("latency", cyc_n - e.cyc, 2);
               if (e.l) m_fcnt++;
            end
         end
         if (acc) begin
            if (!m_open) begin
               m_mode  = int'(mode);
               m_param = int'(param);
            end
            e.d   = use_fixed ? fixed_exp : ref_px(m_mode, m_param, in_if.data);
            e.l   = in_if.last;
            e.cyc = cyc_n;
            q.push_back(e);
            m_open = !in_if.last;
         end
      end
      last_acc = acc;
      @(posedge clk);
      cyc_n++;
      #1;
      if (reset) begin
         q.delete();
         m_open  = 0;
         m_mode  = 0;
         m_param = 0;
         m_fcnt  = '0;
      end
      if (rand_rdy) out_if.ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [PW-1:0] d, input logic l);
      in_if.valid = 1'b1;
      in_if.data  = d;
      in_if.last  = l;
      last_acc    = 0;
      for (int k = 0; k < 60; k++) begin
         cyc();
         if (last_acc) break;
      end
      if (!last_acc) chk("accept_timeout", 0, 1);
      in_if.valid = 1'b0;
      in_if.data  = PW'($urandom);
      use_fixed   = 0;
   endtask

   task automatic send_fx(input logic [PW-1:0] d, input logic l, input logic [PW-1:0] fx);
      use_fixed = 1;
      fixed_exp = fx;
      send(d, l);
   endtask

   task automatic drain();
      in_if.valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (q.size() == 0) break;
         cyc();
      end
      cyc();
      cyc();
      if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 0);
   endtask

   initial begin
      reset        = 1'b1;
      mode         = 3'd0;
      param        = '0;
      in_if.valid  = 1'b0;
      in_if.data   = '0;
      in_if.last   = 1'b0;
      out_if.ready = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      chk("rst_out_valid", 32'(out_if.valid), 0);
      chk("rst_out_data", 32'(out_if.data), 0);
      chk("rst_out_last", 32'(out_if.last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_frame_cnt", 32'(frame_cnt), 0);
      cyc();

      // Invert frame of four back-to-back pixels with exact two-cycle latency.
      lat_chk = 1;
      mode = 3'd1;
      send_fx(px(10, 20, 30), 1'b0, px(245, 235, 225));
      send(px(1, 2, 3), 1'b0);
      send(px(0, 128, 255), 1'b0);
      send_fx(px(40, 50, 60), 1'b1, px(215, 205, 195));
      drain();
      chk("frame_cnt_one", 32'(frame_cnt), 1);

      mode = 3'd2; param = 8'd100;
      send_fx(px(200, 50, 155), 1'b1, px(255, 150, 255));
      mode = 3'd3; param = 8'd100;
      send_fx(px(200, 50, 100), 1'b1, px(100, 0, 0));
      mode = 3'd5;
      send_fx(px(10, 20, 31), 1'b1, px(20, 20, 20));
      mode = 3'd4; param = 8'd128;
      send_fx(px(127, 128, 255), 1'b1, px(0, 255, 255));
      mode = 3'd6;
      send_fx(px(1, 2, 3), 1'b1, px(3, 2, 1));
      mode = 3'd7;
      send_fx(px(9, 8, 7), 1'b1, px(9, 8, 7));
      drain();

      // Mode input changes mid-frame; the frame keeps its latched invert.
      mode = 3'd1;
      send(px(11, 22, 33), 1'b0);
      mode = 3'd0;
      send_fx(px(44, 55, 66), 1'b0, px(211, 200, 189));
      send(px(77, 88, 99), 1'b1);
      send_fx(px(12, 34, 56), 1'b1, px(12, 34, 56));
      drain();
      lat_chk = 0;

      // Random backpressure with random frames, modes and params.
      rand_rdy = 1;
      for (int i = 0; i < 100; i++) begin
         mode  = 3'($urandom_range(0, 7));
         param = DW'($urandom);
         send(PW'($urandom), 1'(($urandom_range(0, 5) == 0) || (i == 99)));
      end
      rand_rdy = 0;
      out_if.ready = 1'b1;
      drain();

      // Reset with two pixels in flight and the frame still open.
      mode = 3'd1;
      send(px(5, 6, 7), 1'b0);
      send(px(8, 9, 10), 1'b0);
      reset = 1'b1;
      in_if.valid = 1'b1;
      in_if.data  = PW'($urandom);
      cyc();
      chk("mid_rst_out_valid", 32'(out_if.valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_frame_cnt", 32'(frame_cnt), 0);
      reset = 1'b0;
      in_if.valid = 1'b0;
      mode = 3'd3; param = 8'd50;
      send_fx(px(200, 50, 10), 1'b1, px(150, 0, 0));
      drain();
      chk("post_rst_frame_cnt", 32'(frame_cnt), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
